// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: direct-mapped one-word-per-line I-cache lookup on pc_in,
// miss fill through the memory controller, and delivery of instr/pc to the queue.
module if_fetch_unit #(
  parameter int ICACHE_LINES = 16,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  pc_to_if_en_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  flush_in,
  input  logic                  iq_full_in,
  output logic                  if_to_pc_en_out,
  output logic                  instr_valid_out,
  output logic [ADDR_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc_out,
  output logic                  if_to_mc_req_out,
  output logic [ADDR_WIDTH-1:0] if_to_mc_addr_out,
  input  logic                  mc_to_if_done_in,
  input  logic [ADDR_WIDTH-1:0] mc_to_if_data_in,
  output logic [1:0]            state_dbg
);

  localparam int IDX   = $clog2(ICACHE_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    MISS  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    deliver, deliver_nxt;
  logic [ADDR_WIDTH-1:0]   instr, instr_nxt;
  logic [ADDR_WIDTH-1:0]   instr_pc, instr_pc_nxt;
  logic                    req, req_nxt;
  logic [ADDR_WIDTH-1:0]   fetch_pc, fetch_pc_nxt;
  logic                    fill_we;

  logic [ICACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
  logic [ADDR_WIDTH-1:0]   line_data [ICACHE_LINES];

  logic [IDX-1:0]          look_idx, fill_idx;
  logic [TAG_W-1:0]        look_tag;
  logic                    hit, issue;
  logic                    unused_pc_bits;

  assign look_idx       = pc_in[IDX+1:2];
  assign look_tag       = pc_in[ADDR_WIDTH-1:IDX+2];
  assign fill_idx       = fetch_pc[IDX+1:2];
  assign hit            = line_valid[look_idx] && (line_tag[look_idx] == look_tag);
  assign issue          = pc_to_if_en_in && !iq_full_in && !flush_in;
  assign unused_pc_bits = ^pc_in[1:0];

  // Handshake: instr_valid_out/if_to_pc_en_out form one single-cycle pulse, raised only
  // for a lookup made while iq_full_in was low; consumers qualify it with rdy_in.
  assign instr_valid_out   = deliver;
  assign if_to_pc_en_out   = deliver;
  assign instr_out         = instr;
  assign instr_pc_out      = instr_pc;
  assign if_to_mc_req_out  = req;
  assign if_to_mc_addr_out = fetch_pc;
  assign state_dbg         = state;

  always_comb begin
    state_nxt    = state;
    deliver_nxt  = 1'b0;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    req_nxt      = req;
    fetch_pc_nxt = fetch_pc;
    fill_we      = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          if (hit) begin
            deliver_nxt  = 1'b1;
            instr_nxt    = line_data[look_idx];
            instr_pc_nxt = pc_in;
            state_nxt    = STALL;
          end else begin
            fetch_pc_nxt = pc_in;
            req_nxt      = 1'b1;
            state_nxt    = MISS;
          end
        end
      end
      // pc_in is stale here while the PC applies the advance.
      STALL: state_nxt = IDLE;
      // A redirect cannot abort the memory read; the fill is still correct for fetch_pc.
      MISS: begin
        if (mc_to_if_done_in) begin
          fill_we   = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= IDLE;
      deliver  <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
      req      <= 1'b0;
      fetch_pc <= '0;
    end else if (rdy_in) begin
      state    <= state_nxt;
      deliver  <= deliver_nxt;
      instr    <= instr_nxt;
      instr_pc <= instr_pc_nxt;
      req      <= req_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      line_valid <= '0;
    end else if (rdy_in && fill_we) begin
      line_valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_we) begin
      line_tag[fill_idx]  <= fetch_pc[ADDR_WIDTH-1:IDX+2];
      line_data[fill_idx] <= mc_to_if_data_in;
    end
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage between the program-counter register and the instruction queue. Takes the current PC, looks it up in a small direct-mapped instruction cache, and on a miss requests the word from the memory controller and fills the line. It hands each fetched instruction with its PC to the queue and returns a one-cycle advance pulse to the PC. It drops in-flight work on a commit redirect.

## Interface
- `ICACHE_LINES`, 16: number of one-word lines; power of two, ≥2; IDX = log2(ICACHE_LINES)
- `ADDR_WIDTH`, 32: address and instruction width
- `clk_in` in 1: single clock, rising edge
- `rst_n_in` in 1: reset, asynchronous, active-low
- `rdy_in` in 1: global enable; low freezes every register
- `pc_to_if_en_in` in 1: `pc_in` is valid this cycle
- `pc_in` in 32: fetch address, word aligned
- `flush_in` in 1: commit redirect; asserted in the same cycle the PC loads its redirect target
- `iq_full_in` in 1: instruction queue cannot accept this cycle
- `if_to_pc_en_out` out 1: one-cycle pulse; PC advances by 4
- `instr_valid_out` out 1: one-cycle pulse; instruction delivered to queue
- `instr_out` out 32: instruction word
- `instr_pc_out` out 32: PC of `instr_out`
- `if_to_mc_req_out` out 1: memory read request, level
- `if_to_mc_addr_out` out 32: request address
- `mc_to_if_done_in` in 1: one-cycle pulse; `mc_to_if_data_in` valid
- `mc_to_if_data_in` in 32: returned word

## Operation
- Cache: index = pc[IDX+1:2], tag = pc[31:IDX+2], one valid bit per line. All valid bits clear on reset. Flush does not clear them.
- FSM states: IDLE, STALL, MISS. All transitions are gated by `rdy_in`.
- IDLE, with `pc_to_if_en_in` high, `flush_in` low, and `iq_full_in` low:
  - Hit: on the edge, register `instr_out` = line data, `instr_pc_out` = `pc_in`, `instr_valid_out` = 1, `if_to_pc_en_out` = 1. Go to STALL.
  - Miss: latch `pc_in` into fetch_pc, raise `if_to_mc_req_out` with `if_to_mc_addr_out` = fetch_pc. Go to MISS.
- IDLE, with `iq_full_in` high or `pc_to_if_en_in` low: no issue, no request, stay in IDLE.
- STALL: hold for exactly one cycle while the PC applies the advance (`pc_in` is stale). No lookup. Go to IDLE.
- MISS: hold the request and address steady until `mc_to_if_done_in`.
  - On done: write data, tag, and valid bit into line index(fetch_pc). Drop the request. Go to IDLE.
  - The next IDLE lookup hits. This costs no extra pulses toward the PC.
- Flush (`flush_in` high):
  - In IDLE or STALL: suppress any issue this cycle. Force `instr_valid_out` and `if_to_pc_en_out` to 0 on the edge. Go to IDLE.
  - In MISS: the request is not withdrawn because the memory controller cannot abort. The fill still completes into the cache, since the data is correct for that address. Go to IDLE afterwards and look up the new `pc_in`.
- Priority per edge: reset > `!rdy_in` (freeze) > `flush_in` > normal operation.
- `if_to_pc_en_out` and `instr_valid_out` are always asserted together and never high for two consecutive cycles.

## Timing
- Reset (async, immediate) values:
  - `if_to_pc_en_out` = 0, `instr_valid_out` = 0, `instr_out` = 0, `instr_pc_out` = 0
  - `if_to_mc_req_out` = 0, `if_to_mc_addr_out` = 0
  - state = IDLE, all valid bits = 0
- Hit latency: PC presented in cycle T → instruction and advance pulse in T+1.
- PC timing around a hit:
  - Cycle T+1 is STALL.
  - The PC updates on the T+1 edge.
  - The new PC is looked up in T+2.
  - Sustained hit throughput is therefore one instruction per 2 cycles.
- Miss latency: request rises in T+1 and is held until done at cycle D. Line is written on the D edge. IDLE in D+1 hits, so the instruction appears in D+2.
- `flush_in` in cycle T: no pulse in T+1. Lookup of the redirected `pc_in` in T+1 at the earliest, or after the fill completes if the unit was in MISS.
- `rdy_in` low: outputs hold their previous values. A pulse that was high stays high until `rdy_in` returns; consumers gate on `rdy_in`.
- `mc_to_if_done_in` outside MISS is ignored.

## Test plan
- Cold miss then hit:
  - Stimulus: reset, `pc_in` = 0x0 with data 0x00000013 returned 3 cycles after request.
  - Response: request address 0x0, line filled, `instr_valid_out` with `instr_out` = 0x00000013, `instr_pc_out` = 0x0. Exactly one `if_to_pc_en_out` pulse.
- Hit stream:
  - Stimulus: preload 0x0, 0x4, 0x8; PC advances on each pulse.
  - Response: instructions delivered on alternate cycles, PCs 0x0, 0x4, 0x8, no memory requests.
- Conflict eviction (ICACHE_LINES = 16):
  - Stimulus: fetch 0x0, then 0x40, then 0x0.
  - Response: three misses, because both addresses map to index 0.
- Queue backpressure:
  - Stimulus: `iq_full_in` high for 5 cycles on a cached PC.
  - Response: no pulses during those cycles; delivery in the cycle after `iq_full_in` falls.
- Flush during miss:
  - Stimulus: `flush_in` in the 2nd MISS cycle, PC redirected to 0x100.
  - Response: the fill for the old address completes; the next request address is 0x100; no instruction from the old PC is delivered.
- Async reset mid-miss:
  - Stimulus: drop `rst_n_in` between clock edges while in MISS.
  - Response: `if_to_mc_req_out` falls immediately, all outputs 0, and a subsequent fetch of the same PC misses again.
